// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch/decode sequencer for the Basic Computer.
//                Holds PC, AR and IR. Fetches one instruction word, resolves
//                indirect memory-reference addressing, then presents the
//                decoded instruction to the execute stage until it retires
//                with ex_done.
//
//  Ports
//    clk          in   1       system clock, all state changes on posedge
//    rst          in   1       synchronous active-high reset
//    mem_rdata    in   DATA_W  memory read data (combinational from mem_adr)
//    mem_read     out  1       memory read strobe (T1 and T3 only)
//    mem_adr      out  ADR_W   memory address, always equal to AR
//    ex_done      in   1       execute stage retired the current instruction
//    pc_load      in   1       with ex_done: PC <= pc_value
//    pc_value     in   ADR_W   branch target / skip value
//    halt         in   1       with ex_done: stop fetching
//    pc, ar, ir   out          architectural registers
//    i_bit        out  1       IR[15] latched at decode
//    opcode       out  3       IR[14:12] latched at decode
//    is_mem_ref   out  1       opcode != 3'b111
//    is_reg_ref   out  1       opcode == 3'b111, i_bit == 0
//    is_io        out  1       opcode == 3'b111, i_bit == 1
//    instr_valid  out  1       decoded instruction presented to execute
//    halted       out  1       sequencer stopped (only rst exits)
//
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int              ADR_W    = 12,
    parameter int              DATA_W   = 16,
    parameter logic [ADR_W-1:0] RESET_PC = 12'h001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic [ADR_W-1:0]  mem_adr,
    input  logic              ex_done,
    input  logic              pc_load,
    input  logic [ADR_W-1:0]  pc_value,
    input  logic              halt,
    output logic [ADR_W-1:0]  pc,
    output logic [ADR_W-1:0]  ar,
    output logic [DATA_W-1:0] ir,
    output logic              i_bit,
    output logic [2:0]        opcode,
    output logic              is_mem_ref,
    output logic              is_reg_ref,
    output logic              is_io,
    output logic              instr_valid,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_T0    = 3'd0,
        S_T1    = 3'd1,
        S_T2    = 3'd2,
        S_T3    = 3'd3,
        S_ISSUE = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [2:0] c_OPC_NONMEM = 3'b111;

    state_t            r_state;
    logic [ADR_W-1:0]  r_pc;
    logic [ADR_W-1:0]  r_ar;
    logic [DATA_W-1:0] r_ir;
    logic              r_i_bit;
    logic [2:0]        r_opcode;
    logic              r_is_mem_ref;
    logic              r_is_reg_ref;
    logic              r_is_io;
    logic              r_instr_valid;
    logic              r_halted;
    logic              r_mem_read;

    // Decode fields taken straight from IR while in T2
    logic [2:0]        w_ir_opcode;
    logic              w_ir_ibit;
    logic              w_ir_nonmem;
    logic              w_ir_indirect;
    logic [ADR_W-1:0]  w_pc_inc;

    assign w_ir_opcode   = r_ir[DATA_W-2:DATA_W-4];
    assign w_ir_ibit     = r_ir[DATA_W-1];
    assign w_ir_nonmem   = (w_ir_opcode == c_OPC_NONMEM);
    // Only memory-reference instructions dereference through memory; for
    // opcode 7 the I bit selects register vs I/O class instead.
    assign w_ir_indirect = w_ir_ibit && !w_ir_nonmem;
    assign w_pc_inc      = r_pc + ADR_W'(1);

    // Single sequencer. Status outputs are registered and set from the
    // state being entered, so they line up exactly with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_T0;
            r_pc          <= RESET_PC;
            r_ar          <= '0;
            r_ir          <= '0;
            r_i_bit       <= 1'b0;
            r_opcode      <= 3'd0;
            r_is_mem_ref  <= 1'b0;
            r_is_reg_ref  <= 1'b0;
            r_is_io       <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_mem_read    <= 1'b0;
        end else begin
            case (r_state)
                S_T0: begin
                    r_ar       <= r_pc;
                    r_mem_read <= 1'b1;
                    r_state    <= S_T1;
                end
                S_T1: begin
                    r_ir       <= mem_rdata;
                    r_pc       <= w_pc_inc;
                    r_mem_read <= 1'b0;
                    r_state    <= S_T2;
                end
                S_T2: begin
                    r_opcode     <= w_ir_opcode;
                    r_i_bit      <= w_ir_ibit;
                    r_ar         <= r_ir[ADR_W-1:0];
                    r_is_mem_ref <= !w_ir_nonmem;
                    r_is_reg_ref <= w_ir_nonmem && !w_ir_ibit;
                    r_is_io      <= w_ir_nonmem && w_ir_ibit;
                    if (w_ir_indirect) begin
                        r_mem_read <= 1'b1;
                        r_state    <= S_T3;
                    end else begin
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_T3: begin
                    // Pointer word: only the low ADR_W bits form the address
                    r_ar          <= mem_rdata[ADR_W-1:0];
                    r_mem_read    <= 1'b0;
                    r_instr_valid <= 1'b1;
                    r_state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (ex_done) begin
                        if (pc_load) begin
                            r_pc <= pc_value;
                        end
                        r_instr_valid <= 1'b0;
                        if (halt) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_state  <= S_T0;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state       <= S_T0;
                    r_instr_valid <= 1'b0;
                    r_mem_read    <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_adr     = r_ar;
    assign pc          = r_pc;
    assign ar          = r_ar;
    assign ir          = r_ir;
    assign i_bit       = r_i_bit;
    assign opcode      = r_opcode;
    assign is_mem_ref  = r_is_mem_ref;
    assign is_reg_ref  = r_is_reg_ref;
    assign is_io       = r_is_io;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. A behavioural
//                4K x 16 memory answers combinationally on mem_adr; each task
//                drives one scenario and compares against hand-computed
//                values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_read;
    logic [11:0] mem_adr;
    logic        ex_done;
    logic        pc_load;
    logic [11:0] pc_value;
    logic        halt;
    logic [11:0] pc;
    logic [11:0] ar;
    logic [15:0] ir;
    logic        i_bit;
    logic [2:0]  opcode;
    logic        is_mem_ref;
    logic        is_reg_ref;
    logic        is_io;
    logic        instr_valid;
    logic        halted;

    logic [15:0] mem [0:4095];

    int n_checks;
    int n_fail;

    int          cyc;
    logic [15:0] rmask;
    logic [11:0] t1_adr;

    fetch_unit #(
        .ADR_W   (12),
        .DATA_W  (16),
        .RESET_PC(12'h001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rdata  (mem_rdata),
        .mem_read   (mem_read),
        .mem_adr    (mem_adr),
        .ex_done    (ex_done),
        .pc_load    (pc_load),
        .pc_value   (pc_value),
        .halt       (halt),
        .pc         (pc),
        .ar         (ar),
        .ir         (ir),
        .i_bit      (i_bit),
        .opcode     (opcode),
        .is_mem_ref (is_mem_ref),
        .is_reg_ref (is_reg_ref),
        .is_io      (is_io),
        .instr_valid(instr_valid),
        .halted     (halted)
    );

    assign mem_rdata = mem[mem_adr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with the sequencer in T0. Counts posedges until
    // instr_valid shows, records which cycles strobed mem_read and the
    // address used in the first (T1) cycle. With noise set, ex_done/pc_load/
    // halt are held high through the fetch states and dropped on issue.
    task automatic wait_valid(input bit noise, output int cycles,
                              output logic [15:0] mask, output logic [11:0] adr1);
        cycles = 0;
        mask   = '0;
        adr1   = '0;
        if (noise) begin
            ex_done  = 1'b1;
            pc_load  = 1'b1;
            pc_value = 12'h3AA;
            halt     = 1'b1;
        end
        while (!instr_valid && cycles < 16) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (mem_read) mask[cycles-1] = 1'b1;
            if (cycles == 1) adr1 = mem_adr;
        end
        ex_done = 1'b0;
        pc_load = 1'b0;
        halt    = 1'b0;
    endtask

    // Retire the instruction in ISSUE with a one-cycle ex_done pulse
    task automatic retire(input logic pl, input logic [11:0] pv, input logic h);
        ex_done  = 1'b1;
        pc_load  = pl;
        pc_value = pv;
        halt     = h;
        @(posedge clk);
        @(negedge clk);
        ex_done  = 1'b0;
        pc_load  = 1'b0;
        halt     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (pc !== 12'h001) begin n_fail++; $display("FAIL reset_pc got %h want 001", pc); end
        n_checks++; if (ar !== 12'h000) begin n_fail++; $display("FAIL reset_ar got %h want 000", ar); end
        n_checks++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir got %h want 0000", ir); end
        n_checks++; if ({instr_valid, halted, mem_read} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status got v/h/r=%b want 000", {instr_valid, halted, mem_read}); end
        n_checks++; if ({i_bit, opcode, is_mem_ref, is_reg_ref, is_io} !== 7'd0) begin
            n_fail++; $display("FAIL reset_decode got %b want 0000000", {i_bit, opcode, is_mem_ref, is_reg_ref, is_io}); end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        wait_valid(1'b0, cyc, rmask, t1_adr);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL direct_latency got %0d want 3", cyc); end
        n_checks++; if (rmask !== 16'h0001) begin n_fail++; $display("FAIL direct_readmask got %h want 0001", rmask); end
        n_checks++; if (t1_adr !== 12'h001) begin n_fail++; $display("FAIL direct_t1_adr got %h want 001", t1_adr); end
        n_checks++; if (ir !== 16'h4064) begin n_fail++; $display("FAIL direct_ir got %h want 4064", ir); end
        n_checks++; if ({i_bit, opcode} !== 4'b0100) begin n_fail++; $display("FAIL direct_i_op got %b want 0100", {i_bit, opcode}); end
        n_checks++; if (ar !== 12'h064) begin n_fail++; $display("FAIL direct_ar got %h want 064", ar); end
        n_checks++; if (pc !== 12'h002) begin n_fail++; $display("FAIL direct_pc got %h want 002", pc); end
        n_checks++; if ({is_mem_ref, is_reg_ref, is_io} !== 3'b100) begin
            n_fail++; $display("FAIL direct_class got %b want 100", {is_mem_ref, is_reg_ref, is_io}); end
        // Second ISSUE cycle: everything held
        @(negedge clk);
        n_checks++; if ({instr_valid, ir, ar, pc} !== {1'b1, 16'h4064, 12'h064, 12'h002}) begin
            n_fail++; $display("FAIL direct_hold got v=%b ir=%h ar=%h pc=%h want 1 4064 064 002", instr_valid, ir, ar, pc); end
        retire(1'b1, 12'h067, 1'b0);
    endtask

    task automatic test_indirect();
        wait_valid(1'b0, cyc, rmask, t1_adr);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL ind_latency got %0d want 4", cyc); end
        n_checks++; if (rmask !== 16'h0005) begin n_fail++; $display("FAIL ind_readmask got %h want 0005", rmask); end
        n_checks++; if (t1_adr !== 12'h067) begin n_fail++; $display("FAIL ind_t1_adr got %h want 067", t1_adr); end
        n_checks++; if (ar !== 12'h12C) begin n_fail++; $display("FAIL ind_ar got %h want 12C", ar); end
        n_checks++; if ({i_bit, opcode} !== 4'b1000) begin n_fail++; $display("FAIL ind_i_op got %b want 1000", {i_bit, opcode}); end
        n_checks++; if ({is_mem_ref, is_reg_ref, is_io} !== 3'b100) begin
            n_fail++; $display("FAIL ind_class got %b want 100", {is_mem_ref, is_reg_ref, is_io}); end
        n_checks++; if (pc !== 12'h068) begin n_fail++; $display("FAIL ind_pc got %h want 068", pc); end
        retire(1'b1, 12'h100, 1'b0);
    endtask

    task automatic test_reg_io();
        // Stray ex_done/pc_load/halt during fetch must be ignored
        wait_valid(1'b1, cyc, rmask, t1_adr);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL reg_latency got %0d want 3", cyc); end
        n_checks++; if (rmask !== 16'h0001) begin n_fail++; $display("FAIL reg_readmask got %h want 0001", rmask); end
        n_checks++; if (ir !== 16'h7800) begin n_fail++; $display("FAIL reg_ir got %h want 7800", ir); end
        n_checks++; if ({is_mem_ref, is_reg_ref, is_io} !== 3'b010) begin
            n_fail++; $display("FAIL reg_class got %b want 010", {is_mem_ref, is_reg_ref, is_io}); end
        n_checks++; if (ar !== 12'h800) begin n_fail++; $display("FAIL reg_ar got %h want 800", ar); end
        n_checks++; if (pc !== 12'h101) begin n_fail++; $display("FAIL reg_pc got %h want 101", pc); end
        retire(1'b0, 12'h000, 1'b0);
        n_checks++; if (pc !== 12'h101) begin n_fail++; $display("FAIL reg_retire_pc got %h want 101", pc); end

        wait_valid(1'b0, cyc, rmask, t1_adr);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL io_latency got %0d want 3", cyc); end
        n_checks++; if (rmask !== 16'h0001) begin n_fail++; $display("FAIL io_readmask got %h want 0001", rmask); end
        n_checks++; if ({i_bit, opcode} !== 4'b1111) begin n_fail++; $display("FAIL io_i_op got %b want 1111", {i_bit, opcode}); end
        n_checks++; if ({is_mem_ref, is_reg_ref, is_io} !== 3'b001) begin
            n_fail++; $display("FAIL io_class got %b want 001", {is_mem_ref, is_reg_ref, is_io}); end
        n_checks++; if (ar !== 12'h080) begin n_fail++; $display("FAIL io_ar got %h want 080", ar); end
        n_checks++; if (pc !== 12'h102) begin n_fail++; $display("FAIL io_pc got %h want 102", pc); end
    endtask

    task automatic test_branch_wrap();
        // pc_load alone in ISSUE: no effect
        pc_load  = 1'b1;
        pc_value = 12'h555;
        @(posedge clk);
        @(negedge clk);
        pc_load  = 1'b0;
        n_checks++; if ({instr_valid, pc} !== {1'b1, 12'h102}) begin
            n_fail++; $display("FAIL noload_pc got v=%b pc=%h want 1 102", instr_valid, pc); end
        retire(1'b1, 12'hFFF, 1'b0);
        n_checks++; if (pc !== 12'hFFF) begin n_fail++; $display("FAIL branch_pc got %h want FFF", pc); end
        wait_valid(1'b0, cyc, rmask, t1_adr);
        n_checks++; if (t1_adr !== 12'hFFF) begin n_fail++; $display("FAIL wrap_t1_adr got %h want FFF", t1_adr); end
        n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL wrap_pc got %h want 000", pc); end
        n_checks++; if ({ir, ar} !== {16'h1234, 12'h234}) begin
            n_fail++; $display("FAIL wrap_ir_ar got %h/%h want 1234/234", ir, ar); end
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL wrap_latency got %0d want 3", cyc); end
    endtask

    task automatic test_halt();
        retire(1'b0, 12'h000, 1'b1);
        n_checks++; if ({halted, instr_valid} !== 2'b10) begin
            n_fail++; $display("FAIL halt_entry got h/v=%b want 10", {halted, instr_valid}); end
        for (int i = 0; i < 20; i++) begin
            // ex_done pulses while halted must not restart anything
            ex_done = i[0];
            @(negedge clk);
            n_checks++; if ({halted, mem_read, instr_valid} !== 3'b100) begin
                n_fail++; $display("FAIL halt_hold cycle %0d got h/r/v=%b want 100", i, {halted, mem_read, instr_valid}); end
        end
        ex_done = 1'b0;
    endtask

    task automatic test_rst_mid_t3();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({halted, pc} !== {1'b0, 12'h001}) begin
            n_fail++; $display("FAIL halt_exit got h=%b pc=%h want 0 001", halted, pc); end
        wait_valid(1'b0, cyc, rmask, t1_adr);
        n_checks++; if ({cyc[3:0], ir} !== {4'd3, 16'h4064}) begin
            n_fail++; $display("FAIL reboot got cyc=%0d ir=%h want 3 4064", cyc, ir); end
        retire(1'b1, 12'h067, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++; if ({mem_read, mem_adr} !== {1'b1, 12'h0CA}) begin
            n_fail++; $display("FAIL t3_reach got r=%b adr=%h want 1 0CA", mem_read, mem_adr); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({pc, ir, ar} !== {12'h001, 16'h0000, 12'h000}) begin
            n_fail++; $display("FAIL rst_t3_regs got pc=%h ir=%h ar=%h want 001 0000 000", pc, ir, ar); end
        n_checks++; if ({instr_valid, mem_read, halted} !== 3'b000) begin
            n_fail++; $display("FAIL rst_t3_status got v/r/h=%b want 000", {instr_valid, mem_read, halted}); end
        wait_valid(1'b0, cyc, rmask, t1_adr);
        n_checks++; if ({cyc[3:0], t1_adr, ir, pc} !== {4'd3, 12'h001, 16'h4064, 12'h002}) begin
            n_fail++; $display("FAIL rst_t3_refetch got cyc=%0d adr=%h ir=%h pc=%h want 3 001 4064 002", cyc, t1_adr, ir, pc); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ex_done  = 1'b0;
        pc_load  = 1'b0;
        pc_value = 12'h000;
        halt     = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        mem[12'h001] = 16'h4064;
        mem[12'h002] = 16'h0000;
        mem[12'h067] = 16'h80CA;
        mem[12'h0CA] = 16'h012C;
        mem[12'h100] = 16'h7800;
        mem[12'h101] = 16'hF080;
        mem[12'hFFF] = 16'h1234;
        @(negedge clk);

        test_reset();
        test_direct();
        test_indirect();
        test_reg_io();
        test_branch_wrap();
        test_halt();
        test_rst_mid_t3();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch/decode sequencer for the Basic Computer.
- Sits directly upstream of the memory unit. It drives the memory address and read strobe, and consumes the read data.
- Holds PC, AR and IR, resolves indirect addressing, then hands the decoded instruction to the execute stage over a valid/done handshake.
- Interrupt cycle is out of scope. The execute stage owns R/IEN.

Parameters:
- RESET_PC, 12'h001, PC value loaded on reset (the boot vector).
- ADR_W, 12, address width. PC/AR width; PC wraps modulo 2^ADR_W.
- DATA_W, 16, instruction/data word width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_rdata  in  16  memory read data; combinational, valid in the same cycle as mem_read/mem_adr.
- mem_read  out  1  memory read strobe.
- mem_adr  out  12  memory address; always equals AR.
- ex_done  in  1  execute stage finished the current instruction; single-cycle pulse.
- pc_load  in  1  with ex_done: replace PC with pc_value (branch/BSA/ISZ skip).
- pc_value  in  12  new PC value.
- halt  in  1  stop fetching after the current instruction retires.
- pc  out  12  program counter.
- ar  out  12  address register (effective address after decode).
- ir  out  16  instruction register.
- i_bit  out  1  IR[15] latched at decode.
- opcode  out  3  IR[14:12] latched at decode.
- is_mem_ref  out  1  opcode != 3'b111.
- is_reg_ref  out  1  opcode == 3'b111 and i_bit == 0.
- is_io  out  1  opcode == 3'b111 and i_bit == 1.
- instr_valid  out  1  decoded instruction is presented to execute.
- halted  out  1  sequencer is stopped.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - PC=RESET_PC; AR=0; IR=0; i_bit=0; opcode=0; class flags=0.
  - instr_valid=0, halted=0, mem_read=0; state=T0.
  - Reset mid-operation abandons the in-flight instruction; no partial update survives.
- States, one cycle each except ISSUE and HALT:
  - T0: AR<=PC. Next T1.
  - T1: mem_read=1 (mem_adr=AR). IR<=mem_rdata; PC<=PC+1 (12-bit, 12'hFFF wraps to 12'h000). Next T2.
  - T2: decode IR. opcode<=IR[14:12]; i_bit<=IR[15]; AR<=IR[11:0]; class flags set per the port definitions.
    - If IR[14:12]!=3'b111 and IR[15]=1, next T3.
    - Otherwise next ISSUE.
  - T3 (indirect): mem_read=1. AR<=mem_rdata[11:0]; upper 4 bits discarded. Next ISSUE.
  - ISSUE:
    - instr_valid=1. IR/AR/PC/flags are held stable.
    - On ex_done: if pc_load, PC<=pc_value; else PC unchanged.
    - On ex_done, next is HALT if halt=1 in that cycle, else T0.
  - HALT: halted=1, instr_valid=0, mem_read=0. Only rst exits.
- mem_read=0 in T0, T2, ISSUE and HALT. mem_adr=AR in all states.
- ex_done and pc_load outside ISSUE are ignored. pc_load without ex_done is ignored.
- halt outside ISSUE has no effect until sampled with ex_done.
- Latency from T0 to instr_valid: 3 cycles for direct/register/IO instructions, 4 for indirect memory-reference.
- Minimum instruction period: 4 cycles (ex_done in the first ISSUE cycle).
- The block never writes memory; the write path belongs to the execute stage.

Test Plan:
- Reset release, mem[1]=16'h4064, ex_done asserted 2 cycles into ISSUE → PC=12'h001 after reset; instr_valid rises on cycle 3 with IR=16'h4064, opcode=3'd4, i_bit=0, AR=12'h064, PC=12'h002.
- Indirect fetch: PC=12'h067, mem[0x067]=16'h80CA, mem[0x0CA]=16'h012C → mem_read asserted in T1 and T3; instr_valid on cycle 4 with AR=12'h12C, i_bit=1, opcode=3'd0, is_mem_ref=1.
- Register-reference 16'h7800 and IO 16'hF080 → no T3 read. is_reg_ref=1 for the first; is_io=1 (i_bit=1, opcode=7) for the second. Both are valid on cycle 3.
- Branch and wrap:
  - ex_done+pc_load with pc_value=12'hFFF → next mem_adr in T1 = 12'hFFF, PC becomes 12'h000.
  - pc_load without ex_done in ISSUE → PC unchanged.
- Halt, then rst mid-T3:
  - ex_done with halt=1 → halted=1 next cycle, mem_read held 0 for 20 cycles.
  - rst pulse asserted while in T3 → state T0, PC=12'h001, IR=0, instr_valid=0.
